// File: rtl/mac_tx_pkg.sv
// mac_tx_pkg: shared constants, FSM state type and byte-wise Ethernet CRC-32 helper
package mac_tx_pkg;
  localparam logic [31:0] CRC32_POLYNOMIAL = 32'hEDB88320;
  localparam int MIN_FRAME_BYTES = 60;
  typedef enum logic [2:0] {IDLE, DATA, PAD, FCS, GAP} state_t;
  function automatic logic [31:0] crc32_byte(input logic [7:0] data, input logic [31:0] remainder);
    logic [31:0] r;
    r = remainder ^ {24'd0, data};
    for (int i = 0; i < 8; i++) r = r[0] ? (r >> 1) ^ CRC32_POLYNOMIAL : r >> 1;
    return r;
  endfunction
endpackage

// File: rtl/mac_tx_rr_arbiter.sv
// mac_tx_rr_arbiter: two-requester round-robin arbiter with one-hot grant
// Ports: clock, reset (sync, active-high), en (arbitrate this cycle),
//        req[1:0] requests, gnt[1:0] one-hot combinational winner.
// A tie goes to the port not granted last; last_grant resets to 1 so port 0 wins the first tie.
module mac_tx_rr_arbiter (
  input  logic       clock,
  input  logic       reset,
  input  logic       en,
  input  logic [1:0] req,
  output logic [1:0] gnt
);
  logic last_grant;
  always_comb gnt = !en ? 2'b00 : req == 2'b11 ? (last_grant ? 2'b01 : 2'b10) : req;
  always_ff @(posedge clock)
    if (reset) last_grant <= 1'b1;
    else if (|gnt) last_grant <= gnt[1];
endmodule

// File: rtl/mac_tx_scheduler.sv
// mac_tx_scheduler: arbitrates two byte-wide AXI-Stream frame sources, appends CRC-32 FCS, enforces inter-frame gap
// Ports: clock, reset (sync, active-high); s0_axis_*/s1_axis_* frame sources (tuser on tlast = errored frame);
//        maxis_* frame + FCS toward the MAC; grant one-hot frame owner; busy high outside IDLE.
// Parameter IFG_CYCLES: idle cycles after the last FCS byte (0 = no gap).
// Macro MAC_TX_PAD_EN: when defined, frames shorter than MIN_FRAME_BYTES are zero-padded before the FCS.
module mac_tx_scheduler
  import mac_tx_pkg::*;
#(
  parameter int unsigned IFG_CYCLES = 12
) (
  input  logic       clock,
  input  logic       reset,
  input  logic [7:0] s0_axis_tdata,
  input  logic       s0_axis_tvalid,
  output logic       s0_axis_tready,
  input  logic       s0_axis_tlast,
  input  logic       s0_axis_tuser,
  input  logic [7:0] s1_axis_tdata,
  input  logic       s1_axis_tvalid,
  output logic       s1_axis_tready,
  input  logic       s1_axis_tlast,
  input  logic       s1_axis_tuser,
  output logic [7:0] maxis_tdata,
  output logic       maxis_tvalid,
  input  logic       maxis_tready,
  output logic       maxis_tlast,
  output logic       maxis_tuser,
  output logic [1:0] grant,
  output logic       busy
);
  state_t      state, state_nx;
  logic        sel;
  logic [1:0]  arb_gnt;
  logic [31:0] crc;
  logic [31:0] fcs;
  logic        err;
  logic [1:0]  fcs_idx;
  logic [7:0]  gap_cnt;
  logic [7:0]  in_data;
  logic        in_valid, in_last, in_user;
  logic        fire;
  logic [1:0]  owner;
  mac_tx_rr_arbiter u_arb (
    .clock (clock),
    .reset (reset),
    .en    (state == IDLE),
    .req   ({s1_axis_tvalid, s0_axis_tvalid}),
    .gnt   (arb_gnt)
  );
  assign in_data  = sel ? s1_axis_tdata : s0_axis_tdata;
  assign in_valid = sel ? s1_axis_tvalid : s0_axis_tvalid;
  assign in_last  = sel ? s1_axis_tlast : s0_axis_tlast;
  assign in_user  = sel ? s1_axis_tuser : s0_axis_tuser;
  assign fire     = maxis_tvalid && maxis_tready;
  assign fcs      = ~crc;
  assign owner    = sel ? 2'b10 : 2'b01;
  assign busy     = state != IDLE;
`ifdef MAC_TX_PAD_EN
  logic [6:0] byte_cnt, cnt_inc;
  assign cnt_inc = byte_cnt == 7'(MIN_FRAME_BYTES) ? byte_cnt : byte_cnt + 7'd1;
`endif
  always_ff @(posedge clock)
    if (reset) state <= IDLE;
    else state <= state_nx;
  always_comb begin
    state_nx = state;
    case (state)
      IDLE: state_nx = |arb_gnt ? DATA : IDLE;
`ifdef MAC_TX_PAD_EN
      DATA: if (fire && in_last) state_nx = cnt_inc < 7'(MIN_FRAME_BYTES) ? PAD : FCS;
      PAD:  if (fire && cnt_inc == 7'(MIN_FRAME_BYTES)) state_nx = FCS;
`else
      DATA: if (fire && in_last) state_nx = FCS;
`endif
      FCS:  if (fire && fcs_idx == 2'd3) state_nx = IFG_CYCLES > 0 ? GAP : IDLE;
      GAP:  if (gap_cnt == 8'(IFG_CYCLES - 1)) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end
  always_comb begin
    maxis_tdata    = 8'h00;
    maxis_tvalid   = 1'b0;
    maxis_tlast    = 1'b0;
    maxis_tuser    = 1'b0;
    s0_axis_tready = 1'b0;
    s1_axis_tready = 1'b0;
    grant          = 2'b00;
    case (state)
      DATA: begin
        maxis_tdata    = in_data;
        maxis_tvalid   = in_valid;
        s0_axis_tready = !sel && maxis_tready;
        s1_axis_tready = sel && maxis_tready;
        grant          = owner;
      end
      PAD: begin
        maxis_tvalid = 1'b1;
        grant        = owner;
      end
      FCS: begin
        maxis_tdata  = fcs[{fcs_idx, 3'b000} +: 8];
        maxis_tvalid = 1'b1;
        maxis_tlast  = fcs_idx == 2'd3;
        maxis_tuser  = err && fcs_idx == 2'd3;
        grant        = owner;
      end
      default: ;
    endcase
  end
  // maxis_tdata already carries the granted byte in DATA and zero in PAD, so one CRC update covers both
  always_ff @(posedge clock)
    if (reset) begin
      sel     <= 1'b0;
      crc     <= '1;
      err     <= 1'b0;
      fcs_idx <= 2'd0;
      gap_cnt <= 8'd0;
`ifdef MAC_TX_PAD_EN
      byte_cnt <= 7'd0;
`endif
    end else begin
      if (state == IDLE && |arb_gnt) begin
        sel <= arb_gnt[1];
        crc <= '1;
        err <= 1'b0;
`ifdef MAC_TX_PAD_EN
        byte_cnt <= 7'd0;
`endif
      end
      if ((state == DATA || state == PAD) && fire) begin
        crc <= crc32_byte(maxis_tdata, crc);
`ifdef MAC_TX_PAD_EN
        byte_cnt <= cnt_inc;
`endif
      end
      if (state == DATA && fire && in_last) err <= in_user;
      if (state == FCS && fire) fcs_idx <= fcs_idx + 2'd1;
      gap_cnt <= state == GAP ? gap_cnt + 8'd1 : 8'd0;
    end
endmodule
